// File: rtl/mssd_pkg.sv
// mssd_pkg: shared definitions for the MSSD transmit scheduler.
//   - mssd_state_e : transmit FSM states (ST_PARITY is only reached when
//                    the MSSD_PARITY_EN macro is defined)
//   - field widths and frame lengths for both build variants
//   - helper functions: one-hot to index, even parity over a frame
package mssd_pkg;

  localparam int MSSD_N_REQ         = 4;
  localparam int MSSD_PN_W          = 2;
  localparam int MSSD_DATA_W        = 4;
  // Cycles from START through STOP, without and with the parity bit.
  localparam int MSSD_FRAME_LEN     = 8;
  localparam int MSSD_FRAME_LEN_PAR = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_PORT   = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } mssd_state_e;

  // Index of the set bit in a one-hot 4-bit vector (0 when none is set).
  function automatic logic [MSSD_PN_W-1:0] mssd_onehot_to_idx(
    input logic [MSSD_N_REQ-1:0] oh
  );
    logic [MSSD_PN_W-1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < MSSD_N_REQ; i++) begin
      if (oh[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

  // Even parity bit over port number and payload: XOR of all six bits.
  function automatic logic mssd_even_parity(
    input logic [MSSD_PN_W-1:0]   pn,
    input logic [MSSD_DATA_W-1:0] payload
  );
    return ^{pn, payload};
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick.
//   req   - request vector, one bit per requester
//   ptr   - last winner; the search starts at ptr+1 and wraps 3 -> 0
//   gnt   - one-hot winner (all zero when no request)
//   valid - high when any request was found
// The pointer register itself lives in the instantiating block.
module rr_arbiter4
  import mssd_pkg::*;
(
  input  logic [MSSD_N_REQ-1:0] req,
  input  logic [MSSD_PN_W-1:0]  ptr,
  output logic [MSSD_N_REQ-1:0] gnt,
  output logic                  valid
);

  logic [MSSD_PN_W-1:0] idx_s;

  // Walk the four positions after the pointer; the first requester found wins.
  always_comb begin
    gnt   = 4'b0000;
    valid = 1'b0;
    idx_s = 2'd0;
    for (int off = 1; off <= MSSD_N_REQ; off++) begin
      // off = 4 truncates to 0, so the last winner is checked last.
      idx_s = ptr + 2'(off);
      if (!valid && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        valid      = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
  end

endmodule

// File: rtl/mssd_tx_sched.sv
// mssd_tx_sched: round-robin transmit scheduler for the MSSD serial line.
// Four requesters share one line; each granted payload goes out as
//   start(0), port number (2b, MSB first), payload (4b, MSB first),
//   [even parity, MSSD_PARITY_EN builds only], stop(1).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   req  - level-sensitive requests, sampled only while idle
//   data - payloads, requester i on data[4i+3:4i], captured at grant
//   gnt  - one-hot, one-cycle pulse in the START cycle of the granted frame
//   sout - serial line, idles high
//   busy - high from START through STOP
//   done - one-cycle pulse during STOP
// Build option: define MSSD_PARITY_EN to add the PARITY bit after DATA.
module mssd_tx_sched
  import mssd_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      sout,
  output logic                      busy,
  output logic                      done
);

  mssd_state_e         state_r, state_nxt_s;
  logic [1:0]          bit_cnt_r, bit_cnt_nxt_s;
  // Pointer holds the last winner, which is also the port number of the
  // frame in flight.
  logic [MSSD_PN_W-1:0]   ptr_r, ptr_nxt_s;
  logic [DATA_W-1:0]      payload_r, payload_nxt_s;
  logic [N_REQ-1:0]       gnt_nxt_s;
  logic                   sout_nxt_s;
  logic                   busy_nxt_s;
  logic                   done_nxt_s;

  logic [N_REQ-1:0]       arb_gnt_s;
  logic                   arb_valid_s;

  rr_arbiter4 u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Next-state and next-output logic; outputs are registered, so each
  // branch produces the line value for the state being entered.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    ptr_nxt_s     = ptr_r;
    payload_nxt_s = payload_r;
    gnt_nxt_s     = '0;
    sout_nxt_s    = 1'b1;
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_nxt_s = ST_START;
          ptr_nxt_s   = mssd_onehot_to_idx(arb_gnt_s);
          gnt_nxt_s   = arb_gnt_s;
          sout_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt_s[i]) begin
              payload_nxt_s = data[i*DATA_W +: DATA_W];
            end else begin
              payload_nxt_s = payload_nxt_s;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        state_nxt_s   = ST_PORT;
        bit_cnt_nxt_s = 2'd1;
        sout_nxt_s    = ptr_r[1];
        busy_nxt_s    = 1'b1;
      end

      ST_PORT: begin
        busy_nxt_s = 1'b1;
        if (bit_cnt_r == 2'd0) begin
          state_nxt_s   = ST_DATA;
          bit_cnt_nxt_s = 2'd3;
          sout_nxt_s    = payload_r[3];
        end else begin
          bit_cnt_nxt_s = bit_cnt_r - 2'd1;
          sout_nxt_s    = ptr_r[bit_cnt_r - 2'd1];
        end
      end

      ST_DATA: begin
        busy_nxt_s = 1'b1;
        if (bit_cnt_r == 2'd0) begin
`ifdef MSSD_PARITY_EN
          state_nxt_s = ST_PARITY;
          sout_nxt_s  = mssd_even_parity(ptr_r, payload_r);
`else
          state_nxt_s = ST_STOP;
          sout_nxt_s  = 1'b1;
          done_nxt_s  = 1'b1;
`endif
        end else begin
          bit_cnt_nxt_s = bit_cnt_r - 2'd1;
          sout_nxt_s    = payload_r[bit_cnt_r - 2'd1];
        end
      end

`ifdef MSSD_PARITY_EN
      ST_PARITY: begin
        state_nxt_s = ST_STOP;
        sout_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b1;
        done_nxt_s  = 1'b1;
      end
`endif

      ST_STOP: begin
        // Always return through IDLE so frames are separated by a high bit.
        state_nxt_s = ST_IDLE;
        sout_nxt_s  = 1'b1;
      end

      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = 2'd0;
        sout_nxt_s    = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 2'd0;
      ptr_r     <= 2'd3;
      payload_r <= '0;
      gnt       <= '0;
      sout      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      ptr_r     <= ptr_nxt_s;
      payload_r <= payload_nxt_s;
      gnt       <= gnt_nxt_s;
      sout      <= sout_nxt_s;
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_mssd_tx_sched.sv
// tb_mssd_tx_sched: directed self-checking bench for mssd_tx_sched.
// Works for both builds; frame expectations follow MSSD_PARITY_EN.
module tb_mssd_tx_sched;
  import mssd_pkg::*;

`ifdef MSSD_PARITY_EN
  localparam int FLEN = MSSD_FRAME_LEN_PAR;
`else
  localparam int FLEN = MSSD_FRAME_LEN;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  gnt;
  logic        sout;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  mssd_tx_sched #(.N_REQ(4), .DATA_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed observation: {sout, busy, done, gnt[3:0]}
  function automatic logic [15:0] obs_vec();
    return {9'd0, sout, busy, done, gnt};
  endfunction

  // Expects the sampling edge to be the next one; checks every frame cycle
  // and the idle cycle after it.
  task automatic frame(input string tag, input logic [3:0] exp_gnt,
                       input logic [1:0] pn, input logic [3:0] pay,
                       input logic [3:0] req_after, input int chg_at,
                       input logic [15:0] data_new);
    logic [9:0] bits;
    logic [3:0] g;
    logic       d;
    bits    = 10'h3FF;
    bits[1] = 1'b0;
    bits[2] = pn[1];
    bits[3] = pn[0];
    bits[4] = pay[3];
    bits[5] = pay[2];
    bits[6] = pay[1];
    bits[7] = pay[0];
`ifdef MSSD_PARITY_EN
    bits[8] = pn[1] ^ pn[0] ^ pay[3] ^ pay[2] ^ pay[1] ^ pay[0];
`endif
    for (int c = 1; c <= FLEN; c++) begin
      tick();
      g = (c == 1) ? exp_gnt : 4'b0000;
      d = (c == FLEN);
      chk($sformatf("%s_c%0d", tag, c), obs_vec(), {9'd0, bits[c], 1'b1, d, g});
      if (c == 1) req = req_after;
      if (c == chg_at) data = data_new;
    end
    tick();
    chk($sformatf("%s_idle", tag), obs_vec(), {9'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    data  = 16'h0000;

    // Reset state
    repeat (2) tick();
    chk("reset", obs_vec(), 16'h0040);
    rst = 1'b0;

    // Quiet line with no requests
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("quiet_%0d", i), obs_vec(), 16'h0040);
    end

    // Single request from requester 0
    req  = 4'b0001;
    data = 16'h000A;
    frame("single", 4'b0001, 2'b00, 4'b1010, 4'b0000, 0, 16'h0000);

    // Re-reset so the pointer restarts at 3, then all four requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req  = 4'b1111;
    data = 16'h6666;
    frame("rr0", 4'b0001, 2'b00, 4'b0110, 4'b1111, 0, 16'h6666);
    frame("rr1", 4'b0010, 2'b01, 4'b0110, 4'b1111, 0, 16'h6666);
    frame("rr2", 4'b0100, 2'b10, 4'b0110, 4'b1111, 0, 16'h6666);
    frame("rr3", 4'b1000, 2'b11, 4'b0110, 4'b1111, 0, 16'h6666);
    frame("rr4", 4'b0001, 2'b00, 4'b0110, 4'b0000, 0, 16'h6666);

    // Payload latched at grant; data changes during DATA are ignored
    req  = 4'b0100;
    data = 16'h0300;
    frame("latch", 4'b0100, 2'b10, 4'b0011, 4'b0000, 5, 16'h0F00);

    // Reset during the third DATA cycle of requester 3's frame
    req  = 4'b1000;
    data = 16'hD000;
    tick();
    chk("abort_start", obs_vec(), {9'd0, 1'b0, 1'b1, 1'b0, 4'b1000});
    req = 4'b0000;
    repeat (5) tick();
    chk("abort_data3", obs_vec(), {9'd0, 1'b0, 1'b1, 1'b0, 4'b0000});
    rst = 1'b1;
    #1;
    chk("abort_async", obs_vec(), 16'h0040);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_quiet_%0d", i), obs_vec(), 16'h0040);
    end

    // Pointer back at 3: requester 1 wins over 3, then 3 goes next
    req  = 4'b1010;
    data = 16'h50B0;
    frame("post1", 4'b0010, 2'b01, 4'b1011, 4'b1000, 0, 16'h50B0);
    frame("post3", 4'b1000, 2'b11, 4'b0101, 4'b0000, 0, 16'h50B0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mssd_tx_sched.md
# mssd_tx_sched

Round-robin transmit scheduler that shares the single MSSD serial line between four requesters. Each requester offers a 4-bit payload. The scheduler grants one requester at a time and serializes its frame onto `sout`, which drives the MSSD detector input directly: start bit, 2-bit port number, 4-bit payload, stop bit. The block sits between the requesting units and the MSSD detector and owns the line timing.

## Interface
- `N_REQ`, default 4, number of requesters; fixed to 4 because the port-number field is 2 bits.
- `DATA_W`, default 4, payload width per requester; must equal the detector payload width.
- `clk` input, 1 bit, rising-edge clock.
- `rst` input, 1 bit, asynchronous, active-high reset. One clock domain only.
- `req` input, 4 bits, per-requester request, level-sensitive.
- `data` input, 16 bits, payloads; requester i uses `data[4i+3:4i]`.
- `gnt` output, 4 bits, one-hot, one-cycle pulse when a payload is latched.
- `sout` output, 1 bit, serial line; idles high.
- `busy` output, 1 bit, high from the START cycle through the STOP cycle.
- `done` output, 1 bit, one-cycle pulse during the STOP cycle.

## Operation
- FSM states: IDLE, START, PORT, DATA, PARITY (only when `MSSD_PARITY_EN` is defined), STOP.
- IDLE
  - `sout`=1.
  - If any `req` bit is set, pick the winner round-robin, latch its index and payload, pulse `gnt[winner]`, go to START.
- START: `sout`=0 for one cycle.
- PORT: 2 cycles, winner index MSB first.
- DATA: 4 cycles, payload MSB first.
- PARITY: 1 cycle (macro builds only).
- STOP: `sout`=1 and `done`=1 for one cycle, then IDLE.
- Bit position inside PORT and DATA comes from a 2-bit down-counter, `bit_cnt`.
  - It loads 1 on entry to PORT and 3 on entry to DATA.
  - The state exits when `bit_cnt`=0.
- Round-robin pointer
  - Holds the last winner; the search starts at last+1 and wraps mod 4 (3 → 0).
  - Reset value is 3, so requester 0 has first priority after reset.
- Request rules
  - `req` is sampled only in IDLE. Changes during a frame are ignored.
  - A requester holds `req` until it sees `gnt`. Dropping `req` before `gnt` withdraws the request.
  - `req` still high in the cycle after `gnt` counts as a new request.
- Payload is captured at grant. Changes to `data` afterwards do not affect the frame in flight.

## Timing
- All outputs are registered.
- Reset values: `sout`=1, `gnt`=0, `busy`=0, `done`=0; state=IDLE; pointer=3; `bit_cnt`=0.
- Latency: a request seen in IDLE at edge k produces `gnt` and `sout`=0 in cycle k+1.
- Frame occupies 8 cycles (START..STOP), 9 with parity.
- At least one IDLE cycle (`sout`=1) always separates frames, so the minimum request-to-request period is 9 cycles (10 with parity).
- Simultaneous requests: exactly one grant per IDLE decision; losers wait for later frames.
- `rst` asserted mid-frame
  - Line returns to `sout`=1 immediately (asynchronous).
  - Frame is aborted and no `done` is produced.
  - Pointer goes back to 3.

## Configuration
- `MSSD_PARITY_EN` defined
  - Adds the PARITY state after DATA.
  - Transmits even parity over port bits plus payload bits (XOR of the 6 bits).
  - Frame is 9 cycles. The detector must be built with the matching option.
- `MSSD_PARITY_EN` undefined: no PARITY state; frame is 8 cycles.

## Structure
- Shared package `mssd_pkg`:
  - state enum
  - `MSSD_PN_W`=2
  - `MSSD_DATA_W`=4
  - frame-length constants for both build variants
- One sub-module, `rr_arbiter4`:
  - combinational round-robin pick from `req` and pointer
  - outputs a one-hot grant and a valid bit
  - the pointer register stays in the top.

## Test plan
- Reset, then no requests for 20 cycles → `sout`=1, `busy`=0, `gnt`=0 throughout.
- `req`=0001, `data[3:0]`=1010 → `gnt`=0001 once; `sout` sequence 0,00,1010,1; `done` pulses in cycle 8 after `gnt`.
- `req`=1111 held steady, every payload 0110 → grants in order 0001, 0010, 0100, 1000, 0001; port fields 00, 01, 10, 11, 00; frames spaced 9 cycles apart.
- `req`=0100 granted, then `data[11:8]` changed to 1111 during DATA → the transmitted payload is still the latched value.
- `rst` asserted in the third DATA cycle → `sout`=1 and `busy`=0 immediately, no `done`; the next `req`=1010 grants requester 1 first.
- Macro build, `req`=0010, `data[7:4]`=1011 → bits 0,01,1011,0(parity),1; frame is 9 cycles.
